uart_tx: RTL and testbench

- UART transmitter: 8 data bits, one start bit, one stop bit, no parity (8N1), LSB first.
- A small write-side FIFO decouples the byte producer from the serial line, so back-to-back bytes go out with no idle gap.
- Pairs with the existing 8N1 receiver on the same CLKS_PER_BIT setting.
- Sits between command/telemetry logic and the board TX pin.

---
 rtl/uart_tx_if.sv | 22 ++
 rtl/uart_tx.sv | 172 +++++++++++++++++
 tb/tb_uart_tx.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte-producer side of the 8N1 transmitter: write strobe/data in, line and FIFO status out.
// The producer takes the master modport and the transmitter takes the slave modport.
interface uart_tx_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Serial;
  logic       o_Tx_Active;
  logic       o_Tx_Done;
  logic       o_Tx_Full;
  logic       o_Tx_Empty;
  logic       o_Tx_Overflow;

  modport master (
    output i_Tx_DV, i_Tx_Byte,
    input  o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Full, o_Tx_Empty, o_Tx_Overflow
  );

  modport slave (
    input  i_Tx_DV, i_Tx_Byte,
    output o_Tx_Serial, o_Tx_Active, o_Tx_Done, o_Tx_Full, o_Tx_Empty, o_Tx_Overflow
  );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by a small byte FIFO.
// Back-to-back frames are sent with no idle gap.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic     i_Clock,
  input  logic     i_Reset,
  uart_tx_if.slave tx
);

  localparam int          PTR_W    = $clog2(FIFO_DEPTH);
  localparam int          CNT_W    = PTR_W + 1;
  localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e             state_q, state_d;
  logic [15:0]        clk_cnt_q, clk_cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shift_q, shift_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               done_q, done_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic               push;
  logic               pop;
  logic               last_clk;

  // Full is authoritative: a write while full is dropped even if a pop happens on the same edge.
  assign push     = tx.i_Tx_DV && !full_q;
  assign last_clk = (clk_cnt_q == LAST_CNT);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    serial_d  = serial_q;
    active_d  = active_q;
    done_d    = 1'b0;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (!empty_q) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = 1'b0;
          active_d  = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (last_clk) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          serial_d  = shift_q[0];
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (last_clk) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            serial_d = 1'b1;
            state_d  = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            serial_d  = shift_q[bit_idx_d];
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (last_clk) begin
          done_d    = 1'b1;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          if (!empty_q) begin
            // Chain straight into the next start bit; the line never returns to idle.
            pop      = 1'b1;
            shift_d  = mem_q[rd_ptr_q];
            serial_d = 1'b0;
            state_d  = START;
          end else begin
            active_d = 1'b0;
            state_d  = IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (!push && pop) count_d = count_q - CNT_W'(1);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));
    empty_d = (count_d == '0);
    ovf_d   = tx.i_Tx_DV && full_q;
  end

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset; clearing the pointers and count is what empties it.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= tx.i_Tx_Byte;
  end

  assign tx.o_Tx_Serial   = serial_q;
  assign tx.o_Tx_Active   = active_q;
  assign tx.o_Tx_Done     = done_q;
  assign tx.o_Tx_Full     = full_q;
  assign tx.o_Tx_Empty    = empty_q;
  assign tx.o_Tx_Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle comparison against a frame-timing model, a serial decoder
// acting as loopback receiver, and a bit-length measurement at CLKS_PER_BIT=434.
module tb_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int CPB_B = 434;

  logic clk;
  logic rst;

  uart_tx_if ifc_a ();
  uart_tx_if ifc_b ();

  uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut_a (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (ifc_a)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_B), .FIFO_DEPTH(DEPTH)) dut_b (
    .i_Clock (clk),
    .i_Reset (rst),
    .tx      (ifc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of pending bytes plus the start time and byte of the frame on the line.
  int         cyc    = 0;
  int         fstart = 0;
  bit         busy   = 1'b0;
  logic [7:0] fbyte  = 8'h00;
  logic       exp_done = 1'b0;
  logic       exp_ovf  = 1'b0;
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  logic [7:0] rx_q[$];
  int         dq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge(input logic dv, input logic [7:0] b);
    int pre;
    pre      = mq.size();
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    cyc++;
    if (busy && (cyc - fstart) == 10 * CPB) begin
      exp_done = 1'b1;
      busy     = 1'b0;
    end
    if (!busy && pre > 0) begin
      fbyte  = mq.pop_front();
      sent.push_back(fbyte);
      busy   = 1'b1;
      fstart = cyc;
    end
    if (dv) begin
      if (pre < DEPTH) mq.push_back(b);
      else             exp_ovf = 1'b1;
    end
  endtask

  function automatic logic [5:0] exp_vec();
    logic ser;
    int   bi;
    ser = 1'b1;
    if (busy) begin
      bi = (cyc - fstart) / CPB;
      if (bi == 0)      ser = 1'b0;
      else if (bi <= 8) ser = fbyte[bi-1];
    end
    return {ser, busy, exp_done, mq.size() == DEPTH, mq.size() == 0, exp_ovf};
  endfunction

  function automatic logic [5:0] obs_vec();
    return {ifc_a.o_Tx_Serial, ifc_a.o_Tx_Active, ifc_a.o_Tx_Done,
            ifc_a.o_Tx_Full, ifc_a.o_Tx_Empty, ifc_a.o_Tx_Overflow};
  endfunction

  // Entered and left on a falling edge; inputs are stable across the rising edge.
  task automatic step(input logic dv, input logic [7:0] b);
    ifc_a.i_Tx_DV   = dv;
    ifc_a.i_Tx_Byte = b;
    @(posedge clk);
    model_edge(dv, b);
    @(negedge clk);
    ifc_a.i_Tx_DV = 1'b0;
    check("outputs", 32'(obs_vec()), 32'(exp_vec()));
    if (ifc_a.o_Tx_Done === 1'b1) dq.push_back(cyc);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 * 10 * CPB && (busy || mq.size() != 0); i++) step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("drain_active", 32'(ifc_a.o_Tx_Active), 32'd0);
    check("drain_empty",  32'(ifc_a.o_Tx_Empty),  32'd1);
  endtask

  task automatic check_rx();
    check("rx_count", rx_q.size(), sent.size());
    for (int i = 0; i < rx_q.size() && i < sent.size(); i++)
      check("rx_byte", 32'(rx_q[i]), 32'(sent[i]));
    rx_q.delete();
    sent.delete();
  endtask

  // Receiver: samples the line mid-bit, timed from the falling edge of the start bit.
  always begin : rx_monitor
    logic [7:0] b;
    @(negedge ifc_a.o_Tx_Serial);
    repeat (CPB / 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = ifc_a.o_Tx_Serial;
    end
    repeat (CPB) @(negedge clk);
    rx_q.push_back(b);
  end

  initial begin : stimulus
    int   edges[$];
    int   t;
    logic prev;

    rst             = 1'b1;
    ifc_a.i_Tx_DV   = 1'b0;
    ifc_a.i_Tx_Byte = 8'h00;
    ifc_b.i_Tx_DV   = 1'b0;
    ifc_b.i_Tx_Byte = 8'h00;
    repeat (2) @(negedge clk);
    check("reset_a", 32'(obs_vec()), 32'(6'b100010));
    check("reset_b", 32'({ifc_b.o_Tx_Serial, ifc_b.o_Tx_Active, ifc_b.o_Tx_Done,
                          ifc_b.o_Tx_Full, ifc_b.o_Tx_Empty, ifc_b.o_Tx_Overflow}), 32'(6'b100010));
    rst = 1'b0;
    step(1'b0, 8'h00);

    // Single byte 0xA5.
    dq.delete();
    step(1'b1, 8'hA5);
    drain();
    check("single_done_count", dq.size(), 1);
    check_rx();

    // Back-to-back frames.
    dq.delete();
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'h3C);
    drain();
    check("b2b_done_count", dq.size(), 3);
    if (dq.size() == 3) begin
      check("b2b_gap_1", dq[1] - dq[0], 10 * CPB);
      check("b2b_gap_2", dq[2] - dq[1], 10 * CPB);
    end
    check_rx();

    // Overflow: five writes while frame 1 is on the line.
    step(1'b1, 8'h81);
    step(1'b0, 8'h00);
    step(1'b1, 8'h82);
    step(1'b1, 8'h83);
    step(1'b1, 8'h84);
    step(1'b1, 8'h85);
    check("ovf_full", 32'(ifc_a.o_Tx_Full), 32'd1);
    step(1'b1, 8'h86);
    check("ovf_pulse", 32'(ifc_a.o_Tx_Overflow), 32'd1);
    step(1'b0, 8'h00);
    check("ovf_pulse_end", 32'(ifc_a.o_Tx_Overflow), 32'd0);
    drain();
    check("ovf_rx_count", rx_q.size(), 5);
    check_rx();

    // Write on the same edge as the stop-bit pop, FIFO at count 1.
    step(1'b1, 8'h5A);
    step(1'b1, 8'hC3);
    for (int i = 0; i < 20 * CPB && !(busy && (cyc + 1 - fstart) == 10 * CPB); i++)
      step(1'b0, 8'h00);
    step(1'b1, 8'h96);
    check("same_edge_empty", 32'(ifc_a.o_Tx_Empty), 32'd0);
    check("same_edge_full",  32'(ifc_a.o_Tx_Full),  32'd0);
    drain();
    check_rx();

    // Randomized traffic.
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 2) == 0, 8'($urandom));
    drain();
    check_rx();

    // Reset during data bit 3 with two bytes queued.
    step(1'b1, 8'h00);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    for (int i = 0; i < 10 * CPB && !(busy && (cyc - fstart) == 4 * CPB + 1); i++)
      step(1'b0, 8'h00);
    check("pre_reset_low", 32'(ifc_a.o_Tx_Serial), 32'd0);
    rst = 1'b1;
    #1;
    check("reset_async", 32'(obs_vec()), 32'(6'b100010));
    @(negedge clk);
    check("reset_held", 32'(obs_vec()), 32'(6'b100010));
    rst = 1'b0;
    mq.delete();
    sent.delete();
    dq.delete();
    busy = 1'b0;
    exp_done = 1'b0;
    exp_ovf  = 1'b0;
    for (int i = 0; i < 60; i++) step(1'b0, 8'h00);
    check("post_reset_done", dq.size(), 0);
    rx_q.delete();
    step(1'b1, 8'h7E);
    drain();
    check_rx();

    // Bit length at CLKS_PER_BIT=434 with 0x55: the line toggles at every bit boundary.
    ifc_b.i_Tx_DV   = 1'b1;
    ifc_b.i_Tx_Byte = 8'h55;
    @(negedge clk);
    ifc_b.i_Tx_DV = 1'b0;
    t    = 0;
    prev = ifc_b.o_Tx_Serial;
    for (int i = 0; i < 10 * CPB_B + 50; i++) begin
      @(negedge clk);
      t++;
      if (ifc_b.o_Tx_Serial !== prev) begin
        edges.push_back(t);
        prev = ifc_b.o_Tx_Serial;
      end
    end
    check("b_edge_count", edges.size(), 10);
    for (int i = 1; i < edges.size(); i++)
      check("b_bit_len", edges[i] - edges[i-1], CPB_B);
    check("b_idle_high", 32'(ifc_b.o_Tx_Serial), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
